// File: rtl/conv_seq_pkg.sv
// Shared types and helpers for the convolution row sequencer.
// CONV_SEQ_ZERO_PAD_EN selects the zero-padded frame (W windows) instead of
// the valid-only frame (W-2 windows).
package conv_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    ISSUE   = 3'd3,
    WAIT    = 3'd4,
    DONE    = 3'd5
  } seq_state_t;

  // Cycles from a ROM address change until rom_data reflects it.
  localparam int ROM_LAT = 1;

  // Windows produced per frame for an image of height w.
  function automatic int num_windows(input int w, input bit pad);
    if (pad) begin
      return w;
    end else begin
      return w - 2;
    end
  endfunction

endpackage

// File: rtl/conv_row_sequencer_line_buf3.sv
// Three-row line buffer. Newest row sits in the top slice of win, the oldest
// row in the bottom slice; each shift pushes the oldest row out.
module line_buf3 #(
  parameter int RW = 192
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clr,
  input  logic            shift_en,
  input  logic            zero_in,
  input  logic [RW-1:0]   din,
  output logic [3*RW-1:0] win
);

  logic [RW-1:0] row_in;

  assign row_in = zero_in ? {RW{1'b0}} : din;

  // Row storage: synchronous reset/clear, shift new row in at the top.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      win <= {(3*RW){1'b0}};
    end else if (clr) begin
      win <= {(3*RW){1'b0}};
    end else if (shift_en) begin
      win <= {row_in, win[3*RW-1:RW]};
    end else begin
      win <= win;
    end
  end

endmodule

// File: rtl/conv_row_sequencer.sv
// Frame controller feeding one 3-row window per output row to the 3x3
// convolution engine. Rows come from a registered image ROM; each window is
// offered with valid/ready and the next row is fetched only after conv_done.
// Define CONV_SEQ_ZERO_PAD_EN to add an all-zero row above and below the
// image (W windows per frame instead of W-2).
module conv_row_sequencer
  import conv_seq_pkg::*;
#(
  parameter int W    = 24,
  parameter int AW   = 9,
  parameter int NIMG = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [$clog2(NIMG)-1:0]  img_sel,
  output logic [AW-1:0]            rom_addr,
  input  logic [W*8-1:0]           rom_data,
  output logic [3*W*8-1:0]         win_o,
  output logic                     win_valid,
  input  logic                     win_ready,
  input  logic                     conv_done,
  output logic [$clog2(W)-1:0]     row_idx,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int RW  = W * 8;
  localparam int IW  = $clog2(NIMG);
  localparam int RIW = $clog2(W);
`ifdef CONV_SEQ_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam int NWIN = num_windows(W, PAD);
  localparam int CW   = $clog2(NWIN + 1);

  seq_state_t     state;
  logic [IW-1:0]  img_sel_q;
  logic [RIW-1:0] row_cnt;
  logic [CW-1:0]  win_cnt;
  logic [1:0]     prime_cnt;
  logic [1:0]     lat_cnt;
  logic           lb_clr;
  logic           lb_shift;
  logic           lb_zero;
`ifdef CONV_SEQ_ZERO_PAD_EN
  logic           rows_exh;
`endif

  // ROM word address of a given row of a given image.
  function automatic logic [AW-1:0] row_addr(input logic [IW-1:0] img,
                                             input logic [RIW-1:0] row);
    return AW'(img) * AW'(W) + AW'(row);
  endfunction

  // Line-buffer controls: clear on frame start, shift on every capture.
  // In padded mode the capture after the last image row injects zeros.
  assign lb_clr   = (state == IDLE) && start;
  assign lb_shift = (state == CAPTURE);
`ifdef CONV_SEQ_ZERO_PAD_EN
  assign lb_zero  = rows_exh;
`else
  assign lb_zero  = 1'b0;
`endif

  line_buf3 #(
    .RW (RW)
  ) u_line_buf (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (lb_clr),
    .shift_en (lb_shift),
    .zero_in  (lb_zero),
    .din      (rom_data),
    .win      (win_o)
  );

  // Sequencer FSM with counters, address generation and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      img_sel_q  <= {IW{1'b0}};
      row_cnt    <= {RIW{1'b0}};
      win_cnt    <= {CW{1'b0}};
      prime_cnt  <= 2'd0;
      lat_cnt    <= 2'd0;
      rom_addr   <= {AW{1'b0}};
      win_valid  <= 1'b0;
      row_idx    <= {RIW{1'b0}};
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef CONV_SEQ_ZERO_PAD_EN
      rows_exh   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          frame_done <= 1'b0;
          if (start) begin
            img_sel_q <= img_sel;
            row_cnt   <= {RIW{1'b0}};
            win_cnt   <= {CW{1'b0}};
            row_idx   <= {RIW{1'b0}};
            lat_cnt   <= 2'd0;
            // The cleared line buffer already holds the padded top row.
            prime_cnt <= PAD ? 2'd1 : 2'd0;
            rom_addr  <= row_addr(img_sel, {RIW{1'b0}});
            busy      <= 1'b1;
`ifdef CONV_SEQ_ZERO_PAD_EN
            rows_exh  <= 1'b0;
`endif
            state     <= FETCH;
          end else begin
            state <= IDLE;
          end
        end

        FETCH: begin
          if (lat_cnt == 2'(ROM_LAT - 1)) begin
            lat_cnt <= 2'd0;
            state   <= CAPTURE;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
            state   <= FETCH;
          end
        end

        CAPTURE: begin
          // Row counter stops at the last image row; no wrap into the next image.
          if (row_cnt == RIW'(W - 1)) begin
`ifdef CONV_SEQ_ZERO_PAD_EN
            rows_exh <= 1'b1;
`endif
            row_cnt  <= row_cnt;
          end else begin
            row_cnt  <= row_cnt + 1'b1;
            rom_addr <= row_addr(img_sel_q, row_cnt + 1'b1);
          end
          if (prime_cnt < 2'd2) begin
            prime_cnt <= prime_cnt + 2'd1;
            state     <= FETCH;
          end else begin
            win_valid <= 1'b1;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            state     <= WAIT;
          end else begin
            state <= ISSUE;
          end
        end

        WAIT: begin
          if (conv_done) begin
            win_cnt <= win_cnt + 1'b1;
            row_idx <= row_idx + 1'b1;
            if (win_cnt + 1'b1 == CW'(NWIN)) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              state <= FETCH;
            end
          end else begin
            state <= WAIT;
          end
        end

        DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          win_valid  <= 1'b0;
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_row_sequencer.sv
// Self-checking bench for conv_row_sequencer: registered ROM model with
// random image contents, directed frames with backpressure, spurious inputs
// and a mid-frame reset, checked against a row-arithmetic window model.
module tb_conv_row_sequencer;

  localparam int W    = 24;
  localparam int AW   = 9;
  localparam int NIMG = 16;
  localparam int RW   = W * 8;
  localparam int WB   = 3 * RW;
  localparam int RIW  = $clog2(W);
`ifdef CONV_SEQ_ZERO_PAD_EN
  localparam bit PAD       = 1'b1;
  localparam int NWIN      = W;
  localparam int FIRST_LAT = 4;
`else
  localparam bit PAD       = 1'b0;
  localparam int NWIN      = W - 2;
  localparam int FIRST_LAT = 6;
`endif

  logic           clk = 1'b0;
  logic           rstn;
  logic           start;
  logic [3:0]     img_sel;
  logic [AW-1:0]  rom_addr;
  logic [RW-1:0]  rom_data;
  logic [WB-1:0]  win_o;
  logic           win_valid;
  logic           win_ready;
  logic           conv_done;
  logic [RIW-1:0] row_idx;
  logic           busy;
  logic           frame_done;

  logic [RW-1:0] rom [0:(1<<AW)-1];
  int            addr_log [$];
  int            errors = 0;
  int            checks = 0;

  conv_row_sequencer #(.W(W), .AW(AW), .NIMG(NIMG)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .img_sel    (img_sel),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .win_o      (win_o),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .conv_done  (conv_done),
    .row_idx    (row_idx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Registered image ROM plus a per-cycle log of the address it was given.
  always @(posedge clk) begin
    rom_data <= rom[rom_addr];
    addr_log.push_back(int'(rom_addr));
  end

  task automatic chk(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Image row r, with rows outside the image reading as zero (padding).
  function automatic logic [RW-1:0] img_row(input int img, input int r);
    if (r < 0 || r >= W) return '0;
    return rom[img * W + r];
  endfunction

  // Window k: oldest row in the low slice, newest row in the high slice.
  function automatic logic [WB-1:0] exp_win(input int img, input int k);
    int top;
    top = PAD ? k - 1 : k;
    return {img_row(img, top + 2), img_row(img, top + 1), img_row(img, top)};
  endfunction

  task automatic wait_valid(input int bound, output int cyc);
    cyc = 0;
    while (!win_valid && cyc < bound) begin
      tick();
      cyc++;
    end
  endtask

  // One frame; bp_win gets 10 cycles of backpressure, abort_win is reset in WAIT.
  task automatic run_frame(input int img, input int bp_win, input int abort_win, input bit spur);
    int base;
    int s_idx;
    int cyc;
    int nw;
    bit ok;
    int q [$];
    logic [WB-1:0] held;
    base = img * W;
    img_sel = 4'(img);
    s_idx = addr_log.size();
    start = 1'b1;
    conv_done = spur;
    tick();
    start = 1'b0;
    conv_done = 1'b0;
    chk("start_addr", WB'(rom_addr), WB'(base));
    chk("busy_on", WB'(busy), WB'(1));
    if (spur) img_sel = 4'(img ^ 3);
    wait_valid(FIRST_LAT + 4, cyc);
    chk("first_lat", WB'(cyc), WB'(FIRST_LAT));
    for (int k = 0; k < NWIN; k++) begin
      if (k > 0) begin
        wait_valid(8, cyc);
        chk("next_lat", WB'(cyc >= 2 && cyc <= 3), WB'(1));
      end
      chk("valid", WB'(win_valid), WB'(1));
      chk("win", win_o, exp_win(img, k));
      chk("row_idx", WB'(row_idx), WB'(k));
      if (k == bp_win) begin
        win_ready = 1'b0;
        held = exp_win(img, k);
        for (int i = 0; i < 10; i++) begin
          conv_done = (i == 3);
          tick();
          conv_done = 1'b0;
          chk("bp_valid", WB'(win_valid), WB'(1));
          chk("bp_hold", win_o, held);
        end
        win_ready = 1'b1;
      end
      tick();
      chk("valid_drop", WB'(win_valid), WB'(0));
      if (k == abort_win) begin
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("rst_addr", WB'(rom_addr), WB'(0));
        chk("rst_win", win_o, WB'(0));
        chk("rst_valid", WB'(win_valid), WB'(0));
        chk("rst_row_idx", WB'(row_idx), WB'(0));
        chk("rst_busy", WB'(busy), WB'(0));
        chk("rst_fdone", WB'(frame_done), WB'(0));
        for (int i = 0; i < 4; i++) begin
          tick();
          chk("rst_no_fdone", WB'(frame_done | busy), WB'(0));
        end
        return;
      end
      nw = $urandom_range(3, 0);
      for (int i = 0; i < nw; i++) begin
        start = spur && (i == 0);
        tick();
        start = 1'b0;
        chk("wait_idle", WB'(win_valid), WB'(0));
      end
      conv_done = 1'b1;
      tick();
      conv_done = 1'b0;
      chk("frame_done", WB'(frame_done), WB'(k == NWIN - 1));
    end
    tick();
    chk("fdone_pulse", WB'(frame_done), WB'(0));
    chk("busy_off", WB'(busy), WB'(0));
    for (int i = s_idx + 1; i < addr_log.size(); i++) begin
      if (q.size() == 0 || q[q.size() - 1] != addr_log[i]) q.push_back(addr_log[i]);
    end
    ok = (q.size() == W);
    for (int i = 0; i < q.size() && ok; i++) begin
      if (q[i] != base + i) ok = 1'b0;
    end
    chk("addr_seq", WB'(ok), WB'(1));
    chk("addr_count", WB'(q.size()), WB'(W));
  endtask

  initial begin
    logic [RW-1:0] row;
    for (int a = 0; a < (1 << AW); a++) begin
      for (int b = 0; b < W; b++) begin
        if (a >= NIMG * W) row[b*8 +: 8] = 8'd0;
        else if (a / W == 5) row[b*8 +: 8] = 8'(a % W);
        else row[b*8 +: 8] = 8'($urandom);
      end
      rom[a] = row;
    end
    rstn = 1'b0;
    start = 1'b0;
    img_sel = 4'd0;
    win_ready = 1'b1;
    conv_done = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    chk("reset_addr", WB'(rom_addr), WB'(0));
    chk("reset_win", win_o, WB'(0));
    chk("reset_valid", WB'(win_valid), WB'(0));
    chk("reset_row_idx", WB'(row_idx), WB'(0));
    chk("reset_busy", WB'(busy), WB'(0));
    chk("reset_fdone", WB'(frame_done), WB'(0));

    run_frame(5, -1, -1, 1'b0);

    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    tick();
    chk("idle_conv_done", WB'(busy | win_valid), WB'(0));

    run_frame(int'($urandom_range(15, 0)), 3, -1, 1'b1);
    run_frame(7, -1, 10, 1'b0);
    run_frame(0, -1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
